pwm_ramp_sequencer: RTL and testbench
=====================================

// Module: pwm_ramp_sequencer
// PURPOSE
//  Drives the duty-cycle register bus of the multi-channel Pwm block (ce/addr/data write port).
//  Host sets a per-channel target duty and step size. On every prescaler tick the sequencer sweeps
//  all channels round-robin, moves each current duty one step toward its target and writes the new
//  value into Pwm. Gives smooth fades without CPU involvement; sits between host regs and Pwm.
// PARAMETERS
//  Resolution    8     duty width; must match Pwm Resolution
//  AddressWidth  2     channel address width; must match Pwm AddressWidth
//  Channels      2**AddressWidth  number of channels (localparam)
//  TickDiv       1000  clk cycles per ramp tick, >=2*Channels+2
// PORTS
//  clk          in   1           system clock, all logic rising-edge
//  rst          in   1           synchronous, active-high reset
//  host_we      in   1           host write strobe, 1 cycle per write
//  host_addr    in   AddressWidth channel selected by host write
//  host_target  in   Resolution  target duty for host_addr
//  host_step    in   Resolution  step per tick for host_addr; 0 = jump to target
//  pwm_ce       out  1           write strobe to Pwm ce
//  pwm_addr     out  AddressWidth  channel address to Pwm addr
//  pwm_data     out  Resolution  duty value to Pwm data
//  at_target    out  Channels    bit i=1 when current[i]==target[i]
//  busy         out  1           1 while a sweep (or init sweep) runs
//  overrun      out  1           sticky: tick lost because one was already pending
// BEHAVIOUR
//  Reset: current/target/step regs=0, pwm_ce=0, pwm_addr=0, pwm_data=0, at_target=all 1,
//   overrun=0, prescaler=0. busy=1 (init sweep pending): first sweep after reset runs without a tick
//   and writes 0 to every channel so Pwm state matches current regs.
//  Host write: target[host_addr], step[host_addr] updated next edge; current untouched.
//   at_target recomputed combinationally from regs. Host writes accepted every cycle, never stalled.
//  Prescaler: counts 0..TickDiv-1, tick pulse when wrapping. Tick sets pending flag; tick while
//   pending already set -> overrun<=1 (cleared only by rst), tick dropped.
//  FSM states: IDLE, CALC, WRITE, NEXT.
//   IDLE: if pending -> clear pending, ch<=0, busy<=1, CALC.
//   CALC (1 cycle): compute nxt for ch (below); current[ch]<=nxt; pwm_addr<=ch; pwm_data<=nxt; WRITE.
//   WRITE: pwm_ce=1 for 2 clk cycles, addr/data held stable (Pwm requires ce held >=2 cycles).
//    Write issued even when nxt==current (keeps Pwm coherent).
//   NEXT: pwm_ce=0; if ch==Channels-1 -> busy<=0, IDLE; else ch<=ch+1, CALC.
//   Sweep latency: 4*Channels cycles from IDLE exit to busy=0.
//  Ramp arithmetic (unsigned, no overflow):
//   step==0 or |target-current|<=step -> nxt=target;
//   current<target -> nxt=current+step; current>target -> nxt=current-step.
//   Difference computed as larger-minus-smaller; never wraps past 0 or 2**Resolution-1.
//  Simultaneous events:
//   host write to ch in CALC of same ch -> CALC uses old target; new one applies next sweep.
//   host write and tick same cycle -> both take effect, independent.
//   rst mid-sweep -> immediate reset, pwm_ce=0 next edge, init sweep restarts.
// STRUCTURE
//  Package pwm_seq_pkg: FSM state encoding localparams (IDLE/CALC/WRITE/NEXT), WRITE hold count 2.
//  Sub-module pwm_tick_prescaler (TickDiv): clk, rst -> tick pulse. Regfiles and FSM in top.
// TESTING
//  Res=8, AW=2, TickDiv=16; bench instantiates Pwm on outputs plus a shadow model of its regs.
//  1 Reset -> busy=1, 4 writes addr 0..3 data 0, each ce 2 cycles, then busy=0, at_target=4'b1111.
//  2 ch0 target=200 step=50 -> ch0 writes 50,100,150,200 on successive ticks, then at_target[0]=1.
//  3 ch1 current=200, target=10 step=64 -> 136,72,10 (last step clamps, no wrap to 8).
//  4 ch2 target=255 step=0 -> 255 on first sweep; ch3 target=255 step=255 -> 255 one step.
//  5 Force two ticks during one sweep (TickDiv=2*Channels+2, stall via long sweep) -> overrun=1.
//  6 rst asserted mid-WRITE -> pwm_ce=0 next edge, all regs 0, init sweep repeats as in 1.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM ramp sequencer.
// FSM encoding and the Pwm write-strobe hold length.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2,
    NEXT  = 2'd3
  } state_t;

  localparam int unsigned WriteHold = 2;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Ramp tick generator.
// Counts 0..TickDiv-1 and pulses tick on the wrap cycle.
module pwm_tick_prescaler #(
  parameter int TickDiv = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TickDiv > 2) ? $clog2(TickDiv) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TickDiv - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramps per-channel Pwm duty toward host targets.
// One round-robin sweep of all channels per prescaler tick.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int Resolution   = 8,
  parameter int AddressWidth = 2,
  parameter int TickDiv      = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         host_we,
  input  logic [AddressWidth-1:0]      host_addr,
  input  logic [Resolution-1:0]        host_target,
  input  logic [Resolution-1:0]        host_step,
  output logic                         pwm_ce,
  output logic [AddressWidth-1:0]      pwm_addr,
  output logic [Resolution-1:0]        pwm_data,
  output logic [2**AddressWidth-1:0]   at_target,
  output logic                         busy,
  output logic                         overrun
);

  localparam int Channels = 2**AddressWidth;

  logic [Resolution-1:0] cur_q [Channels];
  logic [Resolution-1:0] tgt_q [Channels];
  logic [Resolution-1:0] stp_q [Channels];

  state_t                state_q, state_d;
  logic [AddressWidth-1:0] ch_q;
  logic [1:0]            hold_q;
  logic                  pending_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  tick;
  logic                  start;
  logic                  last;
  logic                  hold_done;

  logic [Resolution-1:0] cur, tgt, stp, diff, nxt;

  pwm_tick_prescaler #(
    .TickDiv(TickDiv)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign last      = (ch_q == AddressWidth'(Channels - 1));
  assign hold_done = (hold_q == 2'(WriteHold - 1));
  assign busy      = busy_q;
  assign overrun   = overrun_q;

  always_comb begin
    for (int i = 0; i < Channels; i++) begin
      at_target[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  // Larger-minus-smaller keeps the step from wrapping past either rail.
  always_comb begin
    cur  = cur_q[ch_q];
    tgt  = tgt_q[ch_q];
    stp  = stp_q[ch_q];
    diff = (cur > tgt) ? (cur - tgt) : (tgt - cur);
    nxt  = tgt;
    if (stp != '0 && diff > stp) begin
      nxt = (cur < tgt) ? (cur + stp) : (cur - stp);
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    pwm_ce  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          start   = 1'b1;
          state_d = CALC;
        end
      end
      CALC:  state_d = WRITE;
      WRITE: begin
        pwm_ce = 1'b1;
        if (hold_done) state_d = NEXT;
      end
      NEXT:  state_d = last ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_q == WRITE) ? hold_q + 2'd1 : 2'd0;
      if (start) begin
        ch_q   <= '0;
        busy_q <= 1'b1;
      end else if (state_q == NEXT) begin
        if (last) busy_q <= 1'b0;
        else      ch_q   <= ch_q + AddressWidth'(1);
      end
    end
  end

  // Init sweep is just a pending tick left over from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= tick | (pending_q & ~start);
      if (tick && pending_q && !start) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_addr <= '0;
      pwm_data <= '0;
    end else if (state_q == CALC) begin
      pwm_addr <= ch_q;
      pwm_data <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Channels; i++) begin
        tgt_q[i] <= '0;
        stp_q[i] <= '0;
      end
    end else if (host_we) begin
      tgt_q[host_addr] <= host_target;
      stp_q[host_addr] <= host_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Channels; i++) cur_q[i] <= '0;
    end else if (state_q == CALC) begin
      cur_q[ch_q] <= nxt;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer.
// Shadows the Pwm register file from the ce/addr/data port.
module tb_pwm_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_we = 1'b0;
  logic [1:0] host_addr = '0;
  logic [7:0] host_target = '0;
  logic [7:0] host_step = '0;

  logic       pwm_ce;
  logic [1:0] pwm_addr;
  logic [7:0] pwm_data;
  logic [3:0] at_target;
  logic       busy;
  logic       overrun;

  logic       ce2;
  logic [1:0] addr2;
  logic [7:0] data2;
  logic [3:0] at2;
  logic       busy2;
  logic       ovr2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int addr;
    int data;
    int run;
    bit stable;
  } wr_t;

  wr_t wq[$];
  int  run = 0;
  int  ra = 0;
  int  rd = 0;
  bit  st = 1'b1;
  int  shadow [4];

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(
    .Resolution(8), .AddressWidth(2), .TickDiv(16)
  ) dut (
    .clk(clk), .rst(rst), .host_we(host_we), .host_addr(host_addr),
    .host_target(host_target), .host_step(host_step),
    .pwm_ce(pwm_ce), .pwm_addr(pwm_addr), .pwm_data(pwm_data),
    .at_target(at_target), .busy(busy), .overrun(overrun)
  );

  pwm_ramp_sequencer #(
    .Resolution(8), .AddressWidth(2), .TickDiv(10)
  ) dut2 (
    .clk(clk), .rst(rst), .host_we(1'b0), .host_addr(2'd0),
    .host_target(8'd0), .host_step(8'd0),
    .pwm_ce(ce2), .pwm_addr(addr2), .pwm_data(data2),
    .at_target(at2), .busy(busy2), .overrun(ovr2)
  );

  always @(negedge clk) begin
    if (pwm_ce) begin
      if (run == 0) begin
        ra <= int'(pwm_addr);
        rd <= int'(pwm_data);
        st <= 1'b1;
      end else if (int'(pwm_addr) != ra || int'(pwm_data) != rd) begin
        st <= 1'b0;
      end
      run <= run + 1;
    end else if (run != 0) begin
      wq.push_back('{ra, rd, run, st});
      shadow[ra] <= rd;
      run <= 0;
    end
  end

  task automatic get_write(input int ch, output wr_t w, output bit ok);
    ok = 1'b0;
    w  = '{-1, -1, 0, 1'b0};
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      while (wq.size() > 0 && !ok) begin
        w = wq.pop_front();
        if (w.addr == ch) ok = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic host_wr(input int ch, input int tg, input int sp);
    host_we     = 1'b1;
    host_addr   = 2'(ch);
    host_target = 8'(tg);
    host_step   = 8'(sp);
    @(negedge clk);
    host_we     = 1'b0;
  endtask

  task automatic expect_ramp(input int ch, input int n, input int exp_v [4]);
    wr_t w;
    bit  ok;
    for (int i = 0; i < n; i++) begin
      get_write(ch, w, ok);
      total++;
      if (!ok || w.data != exp_v[i] || w.run != 2 || !w.stable) begin
        bad++;
        $display("FAIL ramp ch%0d step%0d: got data=%0d run=%0d stable=%0b ok=%0b want data=%0d run=2",
                 ch, i, w.data, w.run, w.stable, ok, exp_v[i]);
      end
    end
  endtask

  task automatic check_init_sweep;
    wr_t w;
    bit  ok;
    for (int i = 0; i < 4; i++) begin
      get_write(i, w, ok);
      total++;
      if (!ok || w.addr != i || w.data != 0 || w.run != 2 || !w.stable) begin
        bad++;
        $display("FAIL init_write%0d: got addr=%0d data=%0d run=%0d ok=%0b want addr=%0d data=0 run=2",
                 i, w.addr, w.data, w.run, ok, i);
      end
    end
    wait_idle(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL init_busy_clear: busy=%0b want 0", busy);
    end
    total++;
    if (at_target !== 4'b1111) begin
      bad++;
      $display("FAIL init_at_target: got %b want 1111", at_target);
    end
    total++;
    if (shadow[0] != 0 || shadow[1] != 0 || shadow[2] != 0 || shadow[3] != 0) begin
      bad++;
      $display("FAIL init_shadow: got %0d %0d %0d %0d want all 0",
               shadow[0], shadow[1], shadow[2], shadow[3]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (busy !== 1'b1 || pwm_ce !== 1'b0 || pwm_addr !== 2'd0 || pwm_data !== 8'd0) begin
      bad++;
      $display("FAIL %s_outputs: busy=%b ce=%b addr=%0d data=%0d want 1 0 0 0",
               tag, busy, pwm_ce, pwm_addr, pwm_data);
    end
    total++;
    if (at_target !== 4'b1111) begin
      bad++;
      $display("FAIL %s_at_target: got %b want 1111", tag, at_target);
    end
    total++;
    if (overrun !== 1'b0 || ovr2 !== 1'b0) begin
      bad++;
      $display("FAIL %s_overrun: got %b/%b want 0/0", tag, overrun, ovr2);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) shadow[i] = -1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    wq.delete();
    rst = 1'b0;
    check_init_sweep();
  endtask

  task automatic test_ramp_up;
    bit ok;
    int e [4] = '{50, 100, 150, 200};
    wait_idle(ok);
    host_wr(0, 200, 50);
    wq.delete();
    total++;
    if (!ok || at_target[0] !== 1'b0) begin
      bad++;
      $display("FAIL up_at_target_pre: got %b idle_ok=%0b want 0", at_target[0], ok);
    end
    expect_ramp(0, 4, e);
    total++;
    if (at_target[0] !== 1'b1 || shadow[0] != 200) begin
      bad++;
      $display("FAIL up_done: at=%b shadow=%0d want 1 200", at_target[0], shadow[0]);
    end
  endtask

  task automatic test_ramp_down_clamp;
    bit ok;
    int j [4] = '{200, 0, 0, 0};
    int e [4] = '{136, 72, 10, 0};
    wait_idle(ok);
    host_wr(1, 200, 0);
    wq.delete();
    expect_ramp(1, 1, j);
    wait_idle(ok);
    host_wr(1, 10, 64);
    wq.delete();
    expect_ramp(1, 3, e);
    total++;
    if (at_target[1] !== 1'b1 || shadow[1] != 10) begin
      bad++;
      $display("FAIL down_done: at=%b shadow=%0d want 1 10", at_target[1], shadow[1]);
    end
  endtask

  task automatic test_jump;
    bit ok;
    int e [4] = '{255, 0, 0, 0};
    wait_idle(ok);
    host_wr(2, 255, 0);
    host_wr(3, 255, 255);
    wq.delete();
    expect_ramp(2, 1, e);
    expect_ramp(3, 1, e);
    total++;
    if (at_target !== 4'b1111) begin
      bad++;
      $display("FAIL jump_at_target: got %b want 1111", at_target);
    end
  endtask

  task automatic test_overrun;
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ovr2 === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL overrun_set: got %b want 1", ovr2);
    end
    repeat (30) @(negedge clk);
    total++;
    if (ovr2 !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b want 1", ovr2);
    end
  endtask

  task automatic test_rst_mid_write;
    bit ok = 1'b0;
    int e [4] = '{0, 0, 0, 0};
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (pwm_ce === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_find_write: ce=%b want 1", pwm_ce);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pwm_ce !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ce: got %b want 0", pwm_ce);
    end
    @(negedge clk);
    check_reset_outputs("midrst");
    for (int i = 0; i < 4; i++) shadow[i] = -1;
    wq.delete();
    rst = 1'b0;
    check_init_sweep();
    expect_ramp(0, 1, e);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_clamp();
    test_jump();
    test_overrun();
    test_rst_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
